muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the 5-stage MIPS pipeline, owning the HI/LO architectural registers. It sits beside the combinational ALU in EX: the ALU produces single-cycle results, while this block accepts a multi-cycle MULT/MULTU/DIV/DIVU request, holds `busy` while it iterates, and returns the result through HI/LO. The hazard unit stalls MFHI/MFLO and any new mult/div issue while `busy` is high.

## Interface
Parameters:
- `N`, 32, operand width; HI and LO are each N bits.

Ports:
- `clk`  input  1  rising-edge clock; the block has one clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request strobe, sampled on the rising edge of `clk`.
- `op`  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
- `a`  input  N  operand A (rs): multiplicand, dividend, or MTHI/MTLO data.
- `b`  input  N  operand B (rt): multiplier or divisor.
- `busy`  output  1  an operation is in flight.
- `done`  output  1  one-cycle pulse when HI/LO have just been updated by MULT or DIV.
- `hi`  output  N  HI register.
- `lo`  output  N  LO register.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - `start`=1 with a MULT or DIV op: latch `a`, `b` and `op`, clear the iteration counter, go to CALC.
  - `start`=1 with MTHI or MTLO: write `a` to `hi` or `lo` at that same edge; stay in IDLE; `done` stays 0.
  - `start`=1 with op 110 or 111: no effect.
- CALC runs for exactly N cycles; counter width is clog2(N)+1.
  - Multiply: shift-add on the operand magnitudes, one bit per cycle, into a 2N-bit accumulator.
  - Divide: restoring division on the magnitudes, one quotient bit per cycle.
  - When the counter reaches N-1, go to FIX.
- FIX, one cycle:
  - Apply the sign corrections.
  - Write HI/LO.
  - Pulse `done` and return to IDLE.
- Signed ops (MULT, DIV):
  - Operate on the absolute values.
  - The product is negated if the operand signs differ.
  - The quotient is negated if the signs differ.
  - The remainder takes the sign of the dividend.
  - Arithmetic is two's complement at 2N bits for multiply and N bits for divide.
- Results:
  - Multiply: `hi` = product[2N-1:N], `lo` = product[N-1:0].
  - Divide: `lo` = quotient, `hi` = remainder.
- Divide by zero (`b`=0): `lo` = all ones and `hi` = the dividend, for both signed and unsigned divide. Latency is unchanged and there is no exception.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
- `start` is ignored while `busy`=1 for every op, including MTHI and MTLO.
- Operands are captured at the start edge; changes on `a`, `b` or `op` during CALC have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Reset during CALC or FIX aborts the operation at that edge. HI/LO clear to 0 and no `done` pulse is produced.
- Start edge E0 puts the FSM in CALC, and `busy`=1 from the cycle after E0.
- Edges E1 through E32 are the CALC iterations; the FSM is in FIX after E32.
- Edge E33:
  - `hi` and `lo` take the new result.
  - `done`=1 for exactly one cycle.
  - `busy`=0.
- Result latency from the start edge to valid HI/LO is N+1 clock edges, which is 33 at N=32. `busy` is high for N+1 cycles.
- Back-to-back operation: `start` in the cycle where `done`=1 is accepted, because the FSM is already IDLE. `busy` then rises again after that edge.
- MTHI/MTLO has 1-edge latency and never asserts `busy`.

## Configuration
- `MULDIV_DIV_EN`: compiles the divide datapath in or out.
  - Defined: DIV and DIVU operate as described above.
  - Undefined:
    - Opcodes 010 and 011 behave as no-ops: no state change, no `busy`, no `done`, HI/LO unchanged.
    - The restoring-divide datapath and the remainder sign-fix logic are not synthesized.
    - MULT, MULTU, MTHI and MTLO are unaffected.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 edges `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` high exactly one cycle; `busy` high 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 -> `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> `lo`=0xFFFFFFFF, `hi`=100.
- DIV a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- With `MULDIV_DIV_EN` undefined, DIVU a=100, b=7 -> no `busy`, no `done`, HI/LO unchanged.
- MTHI a=0x12345678, then MULT issued and `start` with MTLO pulsed mid-CALC -> `hi`=0x12345678 after 1 edge; the MTLO is ignored; `rst` at edge E10 of a second MULT gives `busy`=0, `hi`=`lo`=0 and no `done`.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide.
// Define MULDIV_DIV_EN to compile in the DIV/DIVU datapath; otherwise those opcodes are no-ops.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   opnd_r;
    logic [2*N-1:0] prod_r;
    logic           neg_q_r;
    logic           go_mul, go_div, go, sa, sb;
    logic [N:0]     mul_sum;
    logic [2*N-1:0] prod_step, prod_fix;
    logic [N-1:0]   res_hi, res_lo;

    function automatic logic [N-1:0] negn(input logic [N-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*N-1:0] neg2n(input logic [2*N-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [N-1:0] mag(input logic [N-1:0] x, input logic sgn);
        return negn(x, sgn & x[N-1]);
    endfunction

    assign go_mul = start && (op[2:1] == 2'b00);
`ifdef MULDIV_DIV_EN
    logic       is_div_r, neg_rem_r, b_zero_r;
    logic [N:0] trial;
    assign go_div = start && (op[2:1] == 2'b01);
`else
    assign go_div = 1'b0;
`endif
    assign go = (state == IDLE) && (go_mul || go_div);
    assign sa = ~op[0] & a[N-1];
    assign sb = ~op[0] & b[N-1];

    // Iteration datapath: one multiplier bit or one quotient bit per cycle
    always_comb begin
        mul_sum   = {1'b0, prod_r[2*N-1:N]} + (prod_r[0] ? {1'b0, opnd_r} : '0);
        prod_step = {mul_sum, prod_r[N-1:1]};
`ifdef MULDIV_DIV_EN
        trial = {prod_r[2*N-1:N], prod_r[N-1]} - {1'b0, opnd_r};
        if (is_div_r)
            prod_step = trial[N] ? {prod_r[2*N-2:0], 1'b0}
                                 : {trial[N-1:0], prod_r[N-2:0], 1'b1};
`endif
    end

    always_comb begin
        prod_fix = neg2n(prod_r, neg_q_r);
        res_hi   = prod_fix[2*N-1:N];
        res_lo   = prod_fix[N-1:0];
`ifdef MULDIV_DIV_EN
        // Divide by zero leaves |a| as remainder, so the dividend sign fix restores a itself
        if (is_div_r) begin
            res_lo = b_zero_r ? '1 : negn(prod_r[N-1:0], neg_q_r);
            res_hi = negn(prod_r[2*N-1:N], neg_rem_r);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            done <= (state == FIX);
            if (go)                cnt <= '0;
            else if (state == CALC) cnt <= cnt + 1'b1;
            if (state == FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == IDLE && start && op == 3'b100) begin
                hi <= a;
            end else if (state == IDLE && start && op == 3'b101) begin
                lo <= a;
            end
        end
    end

    // Operand capture at the start edge; datapath registers carry no reset
    always_ff @(posedge clk) begin
        if (go) begin
            opnd_r  <= go_div ? mag(b, ~op[0]) : mag(a, ~op[0]);
            prod_r  <= {{N{1'b0}}, (go_div ? mag(a, ~op[0]) : mag(b, ~op[0]))};
            neg_q_r <= sa ^ sb;
`ifdef MULDIV_DIV_EN
            is_div_r  <= go_div;
            neg_rem_r <= sa;
            b_zero_r  <= (b == '0);
`endif
        end else if (state == CALC) begin
            prod_r <= prod_step;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;
    localparam int N = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIVEN = 1'b1;
`else
    localparam bit DIVEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic         busy, done;
    logic [N-1:0] hi, lo;
    int checks = 0;
    int errors = 0;

    muldiv_unit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_cyc);
        int bc = 0;
        int dc = 0;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            if (done) dc++;
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk({tag, " busy cycles"}, bc, exp_cyc);
        chk({tag, " done pulses"}, dc, (exp_cyc != 0) ? 1 : 0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        int dseen;
        int bc;
        rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        rst = 1'b0;

        do_op("multu max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
        @(posedge clk); #1;
        chk("done single cycle", done, 0);

        do_op("mult -3*7", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);

        do_op("div -7/2", 3'b010, 32'hFFFFFFF9, 32'd2,
              DIVEN ? 32'hFFFFFFFF : 32'hFFFFFFFF, DIVEN ? 32'hFFFFFFFD : 32'hFFFFFFEB,
              DIVEN ? 33 : 0);
        do_op("div 7/-2", 3'b010, 32'd7, 32'hFFFFFFFE,
              DIVEN ? 32'h00000001 : 32'hFFFFFFFF, DIVEN ? 32'hFFFFFFFD : 32'hFFFFFFEB,
              DIVEN ? 33 : 0);
        do_op("divu by zero", 3'b011, 32'd100, 32'd0,
              DIVEN ? 32'd100 : 32'hFFFFFFFF, DIVEN ? 32'hFFFFFFFF : 32'hFFFFFFEB,
              DIVEN ? 33 : 0);
        do_op("div -9 by zero", 3'b010, 32'hFFFFFFF7, 32'd0,
              DIVEN ? 32'hFFFFFFF7 : 32'hFFFFFFFF, DIVEN ? 32'hFFFFFFFF : 32'hFFFFFFEB,
              DIVEN ? 33 : 0);
        do_op("div overflow", 3'b010, 32'h80000000, 32'hFFFFFFFF,
              DIVEN ? 32'h00000000 : 32'hFFFFFFFF, DIVEN ? 32'h80000000 : 32'hFFFFFFEB,
              DIVEN ? 33 : 0);
        do_op("divu 100/7", 3'b011, 32'd100, 32'd7,
              DIVEN ? 32'd2 : 32'hFFFFFFFF, DIVEN ? 32'd14 : 32'hFFFFFFEB,
              DIVEN ? 33 : 0);

        do_op("mult minint sq", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33);
        do_op("nop 110", 3'b110, 32'h11111111, 32'h2, 32'h40000000, 32'h00000000, 0);

        // MTHI then a MULT with an MTLO and operand changes issued mid-iteration
        start = 1'b1; op = 3'b100; a = 32'h12345678; b = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mthi hi", hi, 32'h12345678);
        chk("mthi busy", busy, 0);
        chk("mthi done", done, 0);

        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; op = 3'b101; a = 32'hDEADBEEF; b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo ignored lo", lo, 32'h00000000);
        chk("mtlo ignored busy", busy, 1);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            bc++;
            @(posedge clk); #1;
        end
        chk("mid-calc done", done, 1);
        chk("mid-calc hi", hi, 32'h00000000);
        chk("mid-calc lo", lo, 32'd30);
        chk("mid-calc remaining busy", bc, 30);

        // Back-to-back: start issued in the done cycle
        do_op("b2b first", 3'b001, 32'd2, 32'd3, 32'd0, 32'd6, 33);
        do_op("b2b second", 3'b001, 32'd4, 32'd5, 32'd0, 32'd20, 33);

        // Reset at edge E10 of a MULT aborts it
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre-abort busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort hi", hi, 0);
        chk("abort lo", lo, 0);
        dseen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dseen++;
            @(posedge clk); #1;
        end
        chk("abort no done later", dseen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
